// File: rtl/cordic_sequencer.sv
// Control FSM for the shared iterative CORDIC datapath: handshakes, load pulse, micro-rotation schedule.
// Optional feature: define CORDIC_SEQ_ABORT_EN to add the abort input.
module cordic_sequencer #(
   parameter int unsigned M     = 32,
   parameter int unsigned ITERS = 24,
   parameter int unsigned IW    = 5
) (
   input  logic          clk,
   input  logic          rst,
`ifdef CORDIC_SEQ_ABORT_EN
   input  logic          abort,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_mode,
   input  logic [M-1:0]  in_x,
   output logic [1:0]    pre_mode,
   output logic [M-1:0]  pre_x,
   output logic          dp_load,
   output logic          dp_en,
   output logic [IW-1:0] dp_shift,
   output logic          dp_hyp,
   output logic          dp_dir,
   input  logic          dp_y_msb,
   input  logic          dp_z_msb,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    out_mode
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ITER,
      ST_DONE
   } state_e;

   localparam logic [IW-1:0] LAST_STEP = IW'(ITERS - 1);
   localparam logic [IW-1:0] HYP_REP_A = IW'(4);
   localparam logic [IW-1:0] HYP_REP_B = IW'(13);

   state_e          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   shift_q, shift_d;
   logic            rep_q, rep_d;
   logic [1:0]      pre_mode_q, pre_mode_d;
   logic [M-1:0]    pre_x_q, pre_x_d;
   logic            in_ready_q, in_ready_d;
   logic            dp_load_q, dp_load_d;
   logic            dp_en_q, dp_en_d;
   logic            out_valid_q, out_valid_d;

   // Next state, step schedule and registered output decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = '0;
      rep_d      = 1'b0;
      pre_mode_d = pre_mode_q;
      pre_x_d    = pre_x_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               pre_mode_d = in_mode;
               pre_x_d    = in_x;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            shift_d = pre_mode_q[1] ? IW'(1) : '0;
            state_d = ST_ITER;
         end
         ST_ITER: begin
            if (cnt_q == LAST_STEP) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + IW'(1);
               // Hyperbolic convergence: indices 4 and 13 are each issued twice
               if (pre_mode_q[1] && !rep_q &&
                   ((shift_q == HYP_REP_A) || (shift_q == HYP_REP_B))) begin
                  shift_d = shift_q;
                  rep_d   = 1'b1;
               end else begin
                  shift_d = shift_q + IW'(1);
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef CORDIC_SEQ_ABORT_EN
      if (abort && ((state_q == ST_LOAD) || (state_q == ST_ITER))) begin
         state_d = ST_IDLE;
         shift_d = '0;
         rep_d   = 1'b0;
      end
`endif

      in_ready_d  = (state_d == ST_IDLE);
      dp_load_d   = (state_d == ST_LOAD);
      dp_en_d     = (state_d == ST_ITER);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         rep_q       <= 1'b0;
         pre_mode_q  <= '0;
         pre_x_q     <= '0;
         in_ready_q  <= 1'b1;
         dp_load_q   <= 1'b0;
         dp_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         rep_q       <= rep_d;
         pre_mode_q  <= pre_mode_d;
         pre_x_q     <= pre_x_d;
         in_ready_q  <= in_ready_d;
         dp_load_q   <= dp_load_d;
         dp_en_q     <= dp_en_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign pre_mode  = pre_mode_q;
   assign pre_x     = pre_x_q;
   assign dp_load   = dp_load_q;
   assign dp_en     = dp_en_q;
   assign dp_shift  = shift_q;
   assign dp_hyp    = pre_mode_q[1];
   assign out_valid = out_valid_q;
   assign out_mode  = pre_mode_q;

   // Direction follows the live datapath signs; held low outside micro-rotation cycles
   assign dp_dir = dp_en_q & (pre_mode_q[0] ? dp_y_msb : ~dp_z_msb);

endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: job-timeline reference model plus directed and random stimulus.
module tb_cordic_sequencer;

   localparam int unsigned M     = 32;
   localparam int unsigned ITERS = 24;
   localparam int unsigned IW    = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          abort;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_mode;
   logic [M-1:0]  in_x;
   logic [1:0]    pre_mode;
   logic [M-1:0]  pre_x;
   logic          dp_load;
   logic          dp_en;
   logic [IW-1:0] dp_shift;
   logic          dp_hyp;
   logic          dp_dir;
   logic          dp_y_msb;
   logic          dp_z_msb;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_mode;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   cordic_sequencer #(.M(M), .ITERS(ITERS), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef CORDIC_SEQ_ABORT_EN
      .abort     (abort),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_x      (in_x),
      .pre_mode  (pre_mode),
      .pre_x     (pre_x),
      .dp_load   (dp_load),
      .dp_en     (dp_en),
      .dp_shift  (dp_shift),
      .dp_hyp    (dp_hyp),
      .dp_dir    (dp_dir),
      .dp_y_msb  (dp_y_msb),
      .dp_z_msb  (dp_z_msb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mode  (out_mode)
   );

   // Shift index of a given step, written as a closed form of the issued sequence
   function automatic int exp_shift(input logic hyp, input int step);
      if (!hyp)     return step;
      if (step < 4) return step + 1;
      if (step < 14) return step;
      return step - 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_k = cycles elapsed since the job was accepted (0 = idle)
   int           m_k;
   logic [1:0]   m_mode;
   logic [M-1:0] m_x;
   logic         e_en;
   logic         e_dir;
   int           e_shift;

   always @(posedge clk) begin
      if (rst) begin
         m_k    <= 0;
         m_mode <= '0;
         m_x    <= '0;
      end else if (m_k == 0) begin
         if (in_valid) begin
            m_k    <= 1;
            m_mode <= in_mode;
            m_x    <= in_x;
         end
      end else if (m_k <= int'(ITERS) + 1) begin
`ifdef CORDIC_SEQ_ABORT_EN
         if (abort) m_k <= 0;
         else
`endif
         m_k <= m_k + 1;
      end else if (out_ready) begin
         m_k <= 0;
      end
   end

   assign e_en    = (m_k >= 2) && (m_k <= int'(ITERS) + 1);
   assign e_dir   = e_en & (m_mode[0] ? dp_y_msb : ~dp_z_msb);
   assign e_shift = e_en ? exp_shift(m_mode[1], m_k - 2) : 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",  32'(in_ready),  32'(m_k == 0));
         chk("dp_load",   32'(dp_load),   32'(m_k == 1));
         chk("dp_en",     32'(dp_en),     32'(e_en));
         chk("dp_shift",  32'(dp_shift),  32'(e_shift));
         chk("dp_dir",    32'(dp_dir),    32'(e_dir));
         chk("dp_hyp",    32'(dp_hyp),    32'(m_mode[1]));
         chk("out_valid", 32'(out_valid), 32'(m_k == int'(ITERS) + 2));
         chk("pre_mode",  32'(pre_mode),  32'(m_mode));
         chk("pre_x",     pre_x,          m_x);
         if (m_k == int'(ITERS) + 2) chk("out_mode", 32'(out_mode), 32'(m_mode));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      dp_y_msb = 1'($urandom);
      dp_z_msb = 1'($urandom);
   endtask

   // Present a request for one cycle; returns in cycle 1 of the job
   task automatic start_job(input logic [1:0] mode, input logic [M-1:0] x);
      in_valid = 1'b1;
      in_mode  = mode;
      in_x     = x;
      tick();
      in_valid = 1'b0;
      in_mode  = 2'($urandom);
      in_x     = $urandom;
   endtask

   initial begin
      rst       = 1'b1;
      abort     = 1'b0;
      in_valid  = 1'b0;
      in_mode   = '0;
      in_x      = '0;
      out_ready = 1'b1;
      dp_y_msb  = 1'b0;
      dp_z_msb  = 1'b0;
      tick();
      tick();
      rst    = 1'b0;
      chk_en = 1'b1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_pre_x",     pre_x,          32'd0);
      tick();

      // Circular rotation, consumer always ready
      start_job(2'b00, 32'h2000_0000);
      chk("t1_load_c1", 32'(dp_load), 32'd1);
      chk("t1_pre_x",   pre_x,        32'h2000_0000);
      tick();
      chk("t1_en_c2",    32'(dp_en),    32'd1);
      chk("t1_shift_c2", 32'(dp_shift), 32'd0);
      repeat (23) tick();
      chk("t1_shift_c25", 32'(dp_shift), 32'd23);
      tick();
      chk("t1_valid_c26", 32'(out_valid), 32'd1);
      chk("t1_en_c26",    32'(dp_en),     32'd0);
      tick();
      chk("t1_valid_c27", 32'(out_valid), 32'd0);
      chk("t1_ready_c27", 32'(in_ready),  32'd1);

      // Hyperbolic rotation shift schedule
      start_job(2'b10, $urandom);
      tick();
      chk("t2_shift_c2", 32'(dp_shift), 32'd1);
      chk("t2_hyp",      32'(dp_hyp),   32'd1);
      repeat (3) tick();
      chk("t2_shift_c5", 32'(dp_shift), 32'd4);
      tick();
      chk("t2_shift_c6", 32'(dp_shift), 32'd4);
      repeat (9) tick();
      chk("t2_shift_c15", 32'(dp_shift), 32'd13);
      tick();
      chk("t2_shift_c16", 32'(dp_shift), 32'd13);
      tick();
      chk("t2_shift_c17", 32'(dp_shift), 32'd14);
      repeat (8) tick();
      chk("t2_shift_c25", 32'(dp_shift), 32'd22);
      tick();
      chk("t2_valid_c26", 32'(out_valid), 32'd1);
      tick();

      // Circular vectoring with back-pressure and an ignored request in DONE
      out_ready = 1'b0;
      start_job(2'b01, $urandom);
      repeat (25) tick();
      for (int i = 0; i < 10; i++) begin
         chk("t3_valid_hold", 32'(out_valid), 32'd1);
         chk("t3_mode_hold",  32'(out_mode),  32'd1);
         chk("t3_ready_low",  32'(in_ready),  32'd0);
         in_valid = (i == 3);
         in_mode  = 2'b11;
         tick();
      end
      in_valid  = 1'b0;
      chk("t3_pre_mode", 32'(pre_mode), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("t3_released", 32'(in_ready), 32'd1);

      // Direction from live signs in rotation and vectoring modes
      start_job(2'b00, $urandom);
      tick();
      dp_z_msb = 1'b1;
      #1 chk("t4_dir_rot_z1", 32'(dp_dir), 32'd0);
      dp_z_msb = 1'b0;
      #1 chk("t4_dir_rot_z0", 32'(dp_dir), 32'd1);
      repeat (ITERS + 1) tick();
      start_job(2'b11, $urandom);
      tick();
      dp_y_msb = 1'b1;
      #1 chk("t4_dir_vec_y1", 32'(dp_dir), 32'd1);
      dp_y_msb = 1'b0;
      #1 chk("t4_dir_vec_y0", 32'(dp_dir), 32'd0);
      repeat (ITERS + 1) tick();

      // Reset in the middle of iterating
      start_job(2'b01, $urandom);
      repeat (11) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_ready", 32'(in_ready), 32'd1);
      chk("t5_en",    32'(dp_en),    32'd0);
      chk("t5_pre_x", pre_x,         32'd0);
      repeat (30) tick();
      start_job(2'b10, $urandom);
      repeat (ITERS + 1) tick();
      chk("t5_next_valid", 32'(out_valid), 32'd1);
      tick();

      // Abort, or plain completion without the abort port
`ifdef CORDIC_SEQ_ABORT_EN
      start_job(2'b00, $urandom);
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t6_en_after_abort",    32'(dp_en),    32'd0);
      chk("t6_ready_after_abort", 32'(in_ready), 32'd1);
      repeat (30) tick();
`else
      start_job(2'b00, $urandom);
      repeat (ITERS + 1) tick();
      chk("t6_completes", 32'(out_valid), 32'd1);
      tick();
`endif

      // Random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 3) == 0);
         in_mode   = 2'($urandom);
         in_x      = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
`ifdef CORDIC_SEQ_ABORT_EN
         abort     = ($urandom_range(0, 40) == 0);
`endif
         rst       = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst      = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
